memoria_data_banked: RTL and testbench

Parametrised, byte-lane-interleaved data memory for the CPU load/store path, replacing the fixed 32-bit four-bank memory with a configurable-width, handshaked, two-stage pipelined block. Byte address `a` lives in lane `a mod LANES`, row `a / LANES`. The block supports byte, half, word and double-word accesses, including sign/zero extension and misaligned accesses that cross a row boundary. It sits between the load/store unit and on-chip RAM, and answers every accepted request with exactly one in-order response.

---
 rtl/memdata_pkg.sv | 51 +++++
 rtl/mem_bank_lane.sv | 27 ++
 rtl/memoria_data_banked.sv | 127 ++++++++++++
 tb/tb_memoria_data_banked.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memdata_pkg.sv
// memdata_pkg: access-size encoding, pipeline payload type and the lane
// mask / load extension helpers shared by memoria_data_banked.
package memdata_pkg;

   localparam int MAX_LANES = 8;
   localparam int MAX_W     = 8 * MAX_LANES;

   typedef enum logic [1:0] {
      BYTE  = 2'd0,
      HALF  = 2'd1,
      WORD  = 2'd2,
      DWORD = 2'd3
   } mem_size_e;

   // attributes of a request travelling from the lane read to the response
   typedef struct packed {
      logic      we;
      logic      uns;
      mem_size_e size;
      logic      err;
   } s1_req_t;

   // lanes touched by an access of 2**size bytes (clamped to lanes) at offset off
   function automatic logic [MAX_LANES-1:0] lane_mask(input mem_size_e size,
                                                      input logic [2:0] off,
                                                      input int lanes);
      logic [MAX_LANES-1:0] m;
      int n;
      m = '0;
      n = 1 << size;
      if (n > lanes) n = lanes;
      for (int k = 0; k < MAX_LANES; k++)
         if (k < n) m[3'((int'(off) + k) % lanes)] = 1'b1;
      return m;
   endfunction

   // keep the low 2**size bytes and sign- or zero-extend them
   function automatic logic [MAX_W-1:0] extend(input logic [MAX_W-1:0] data,
                                                input mem_size_e size,
                                                input logic uns);
      logic [MAX_W-1:0] r;
      case (size)
         BYTE:    r = {{(MAX_W-8){~uns & data[7]}},   data[7:0]};
         HALF:    r = {{(MAX_W-16){~uns & data[15]}}, data[15:0]};
         WORD:    r = {{(MAX_W-32){~uns & data[31]}}, data[31:0]};
         default: r = data;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mem_bank_lane.sv
// mem_bank_lane: one byte lane, 8 bits wide, 2**DEPTH_W deep synchronous RAM.
// Read data q holds its value on cycles with ren low.
module mem_bank_lane
   import memdata_pkg::*;
#(
   parameter int DEPTH_W = 14
)(
   input  logic               clk,
   input  logic               wen,
   input  logic               ren,
   input  logic [DEPTH_W-1:0] wadd,
   input  logic [DEPTH_W-1:0] radd,
   input  logic [7:0]         data,
   output logic [7:0]         q
);

   logic [7:0] ram [0:(1<<DEPTH_W)-1];

   // write port
   always_ff @(posedge clk)
      if (wen) ram[wadd] <= data;

   // read port; output register only loads on a read
   always_ff @(posedge clk)
      if (ren) q <= ram[radd];

endmodule

// File: rtl/memoria_data_banked.sv
// memoria_data_banked: byte-lane-interleaved data memory, two-stage pipeline
// (lane read, then align/extend into the response register) with a
// valid/ready handshake on both sides.
// Optional feature macro MEMDATA_MISALIGN_TRAP_EN: misaligned accesses are
// suppressed and answered with Rsp_err=1.
module memoria_data_banked
   import memdata_pkg::*;
#(
   parameter  int LANES  = 4,
   parameter  int ADDR_W = 16,
   localparam int DATA_W = 8 * LANES
)(
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              Req_valid,
   output logic              Req_ready,
   input  logic              Req_we,
   input  logic [1:0]        Req_size,
   input  logic              Req_unsigned,
   input  logic [31:0]       Req_addr,
   input  logic [DATA_W-1:0] Req_wdata,
   output logic              Rsp_valid,
   input  logic              Rsp_ready,
   output logic              Rsp_we,
   output logic [DATA_W-1:0] Rsp_rdata,
   output logic              Rsp_err
);

   localparam int LOG_L  = $clog2(LANES);
   localparam int ROW_W  = ADDR_W - LOG_L;
   localparam int STAGES = 2;

   logic                  advance, accept, req_err;
   logic [LOG_L-1:0]      off, s1_off;
   logic [ROW_W-1:0]      row;
   mem_size_e             eff_size;
   logic [LANES-1:0]      mask;
   logic [LANES-1:0][7:0] q_bus;
   logic [DATA_W-1:0]     rot;
   s1_req_t               s1;
   logic [STAGES:1]       vld_pipe;
   logic                  unused_addr;

   assign advance   = !Rsp_valid || Rsp_ready;
   assign Req_ready = advance;
   assign accept    = Req_valid && advance;
   assign Rsp_valid = vld_pipe[STAGES];

   assign off      = Req_addr[LOG_L-1:0];
   assign row      = Req_addr[ADDR_W-1:LOG_L];
   assign eff_size = (int'(Req_size) > LOG_L) ? mem_size_e'(2'(LOG_L)) : mem_size_e'(Req_size);
   assign mask     = LANES'(lane_mask(eff_size, 3'(off), LANES));

   generate
      if (ADDR_W < 32) begin : g_unused
         assign unused_addr = ^Req_addr[31:ADDR_W];
      end else begin : g_no_unused
         assign unused_addr = 1'b0;
      end
   endgenerate

`ifdef MEMDATA_MISALIGN_TRAP_EN
   assign req_err = |(off & LOG_L'((1 << eff_size) - 1));
`else
   assign req_err = 1'b0;
`endif

   // lane i holds byte (i-off) mod LANES of the access; lanes below off spill to the next row
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [ROW_W-1:0] lane_row;
      logic [LOG_L-1:0] bsel;
      assign lane_row = (LOG_L'(i) < off) ? row + ROW_W'(1) : row;
      assign bsel     = LOG_L'(i) - off;

      mem_bank_lane #(.DEPTH_W(ROW_W)) u_lane (
         .clk  (Clk),
         .wen  (accept && Req_we && mask[i] && !req_err && Reset_n),
         .ren  (accept),
         .wadd (lane_row),
         .radd (lane_row),
         .data (Req_wdata[{bsel, 3'b000} +: 8]),
         .q    (q_bus[i])
      );
   end

   // rotate lane data down so byte 0 of the access sits at bit 0
   always_comb begin
      rot = '0;
      for (int k = 0; k < LANES; k++)
         rot[8*k +: 8] = q_bus[LOG_L'(k) + s1_off];
   end

   // stage 1: request attributes travel alongside the lane reads
   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) begin
         vld_pipe <= '0;
         s1       <= '0;
         s1_off   <= '0;
      end else if (advance) begin
         vld_pipe <= {vld_pipe[STAGES-1:1], accept};
         if (accept) begin
            s1     <= '{we: Req_we, uns: Req_unsigned, size: eff_size, err: req_err};
            s1_off <= off;
         end
      end

   // stage 2: response register; stores and trapped accesses return zero data
   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) begin
         Rsp_we    <= 1'b0;
         Rsp_rdata <= '0;
      end else if (advance) begin
         Rsp_we    <= vld_pipe[1] & s1.we;
         Rsp_rdata <= (!vld_pipe[1] || s1.we || s1.err) ? '0 :
                      DATA_W'(extend(MAX_W'(rot), s1.size, s1.uns));
      end

`ifdef MEMDATA_MISALIGN_TRAP_EN
   // misalignment flag follows its request into the response
   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n)     Rsp_err <= 1'b0;
      else if (advance) Rsp_err <= vld_pipe[1] & s1.err;
`else
   assign Rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_memoria_data_banked.sv
// tb_memoria_data_banked: directed scenarios plus randomized traffic checked
// against a flat byte-array model of the memory.
module tb_memoria_data_banked;

   localparam int LANES  = 4;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;
`ifdef MEMDATA_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic              Clk = 1'b0, Reset_n = 1'b0;
   logic              Req_valid = 1'b0, Req_we = 1'b0, Req_unsigned = 1'b0, Rsp_ready = 1'b1;
   logic [1:0]        Req_size = 2'd0;
   logic [31:0]       Req_addr = '0;
   logic [DATA_W-1:0] Req_wdata = '0;
   logic              Req_ready, Rsp_valid, Rsp_we, Rsp_err;
   logic [DATA_W-1:0] Rsp_rdata;

   int errors = 0, checks = 0;

   typedef struct { logic we; logic [31:0] rdata; logic err; } exp_t;
   typedef struct { logic we; logic [1:0] sz; logic uns; logic [31:0] a; logic [31:0] wd; } op_t;

   logic [7:0] mem [0:65535];
   exp_t expq[$];

   memoria_data_banked #(.LANES(LANES), .ADDR_W(ADDR_W)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Req_valid(Req_valid), .Req_ready(Req_ready),
      .Req_we(Req_we), .Req_size(Req_size), .Req_unsigned(Req_unsigned),
      .Req_addr(Req_addr), .Req_wdata(Req_wdata), .Rsp_valid(Rsp_valid),
      .Rsp_ready(Rsp_ready), .Rsp_we(Rsp_we), .Rsp_rdata(Rsp_rdata), .Rsp_err(Rsp_err)
   );

   always #5 Clk = ~Clk;

   // ---------------- reference model: flat byte memory ----------------
   function automatic int nb(input logic [1:0] sz);
      int n;
      n = 1 << sz;
      return (n > LANES) ? LANES : n;
   endfunction

   function automatic exp_t mdl(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] a, input logic [31:0] wd);
      exp_t e;
      int n;
      logic [31:0] v;
      logic s;
      n = nb(sz);
      v = '0;
      e.we = we;
      e.err = TRAP && ((a % n) != 0);
      e.rdata = '0;
      if (e.err) return e;
      if (we) begin
         for (int k = 0; k < n; k++) mem[(a + k) & 32'hFFFF] = wd[8*k +: 8];
         return e;
      end
      for (int k = 0; k < n; k++) v[8*k +: 8] = mem[(a + k) & 32'hFFFF];
      s = !uns && v[8*n-1];
      for (int k = n; k < 4; k++) v[8*k +: 8] = s ? 8'hFF : 8'h00;
      e.rdata = v;
      return e;
   endfunction

   // ---------------- drivers (no checking) ----------------
   // called at a falling edge; returns at the falling edge after the accepting edge
   task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, output bit ok);
      int n;
      n = 0;
      Req_valid = 1'b1; Req_we = we; Req_size = sz; Req_unsigned = uns;
      Req_addr = a; Req_wdata = wd;
      #1;
      while (!Req_ready && n < 200) begin @(negedge Clk); #1; n++; end
      ok = Req_ready;
      @(negedge Clk);
      Req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output logic we, output logic [31:0] rd, output logic er, output int lat);
      lat = 0;
      while (!Rsp_valid && lat < 20) begin @(negedge Clk); lat++; end
      we = Rsp_we; rd = Rsp_rdata; er = Rsp_err;
      @(negedge Clk);
   endtask

   task automatic run_op(input op_t o, output exp_t g, output int lat, output bit ok);
      issue(o.we, o.sz, o.uns, o.a, o.wd, ok);
      wait_rsp(g.we, g.rdata, g.err, lat);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      Reset_n = 1'b0;
      @(negedge Clk);
      checks++;
      if (Req_ready !== 1'b1 || Rsp_valid !== 1'b0 || Rsp_we !== 1'b0 || Rsp_rdata !== '0 || Rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_in got ready=%b valid=%b we=%b rdata=%h err=%b want 1 0 0 0 0",
                  Req_ready, Rsp_valid, Rsp_we, Rsp_rdata, Rsp_err);
      end
      Reset_n = 1'b1;
      @(negedge Clk);
      checks++;
      if (Req_ready !== 1'b1 || Rsp_valid !== 1'b0 || Rsp_rdata !== '0 || Rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_out got ready=%b valid=%b rdata=%h err=%b want 1 0 0 0",
                  Req_ready, Rsp_valid, Rsp_rdata, Rsp_err);
      end
   endtask

   task automatic test_word_roundtrip();
      op_t o; exp_t e, g; int lat; bit ok;
      o = '{1'b1, 2'd2, 1'b0, 32'h0100, 32'hDEADBEEF};
      e = mdl(o.we, o.sz, o.uns, o.a, o.wd);
      run_op(o, g, lat, ok);
      checks++;
      if (!ok || lat != 1 || g.we !== 1'b1 || g.rdata !== 32'h0 || g.err !== 1'b0) begin
         errors++;
         $display("FAIL word_store got ok=%0d lat=%0d we=%b rdata=%h err=%b want lat=1 we=1 rdata=0 err=0",
                  ok, lat, g.we, g.rdata, g.err);
      end
      o = '{1'b0, 2'd2, 1'b0, 32'h0100, 32'h0};
      e = mdl(o.we, o.sz, o.uns, o.a, o.wd);
      run_op(o, g, lat, ok);
      checks++;
      if (!ok || lat != 1 || g.we !== 1'b0 || g.rdata !== 32'hDEADBEEF || g.rdata !== e.rdata) begin
         errors++;
         $display("FAIL word_load got ok=%0d lat=%0d we=%b rdata=%h want lat=1 we=0 rdata=deadbeef",
                  ok, lat, g.we, g.rdata);
      end
   endtask

   task automatic test_sub_word();
      op_t ops[$]; exp_t e, g; int lat; bit ok;
      ops.push_back('{1'b1, 2'd2, 1'b0, 32'h0200, 32'h44332211});
      ops.push_back('{1'b1, 2'd0, 1'b0, 32'h0203, 32'h00000080});
      ops.push_back('{1'b0, 2'd0, 1'b0, 32'h0203, 32'h0});
      ops.push_back('{1'b0, 2'd0, 1'b1, 32'h0203, 32'h0});
      ops.push_back('{1'b0, 2'd2, 1'b0, 32'h0200, 32'h0});
      ops.push_back('{1'b0, 2'd1, 1'b0, 32'h0202, 32'h0});
      ops.push_back('{1'b0, 2'd3, 1'b1, 32'h0200, 32'h0});
      foreach (ops[i]) begin
         e = mdl(ops[i].we, ops[i].sz, ops[i].uns, ops[i].a, ops[i].wd);
         run_op(ops[i], g, lat, ok);
         checks++;
         if (!ok || lat != 1 || g.we !== e.we || g.rdata !== e.rdata || g.err !== e.err) begin
            errors++;
            $display("FAIL sub_word[%0d] got lat=%0d we=%b rdata=%h err=%b want lat=1 we=%b rdata=%h err=%b",
                     i, lat, g.we, g.rdata, g.err, e.we, e.rdata, e.err);
         end
      end
   endtask

   task automatic test_misaligned();
      op_t ops[$]; exp_t e, g; int lat; bit ok;
      ops.push_back('{1'b1, 2'd2, 1'b0, 32'h0000, 32'h55667788});
      ops.push_back('{1'b1, 2'd2, 1'b0, 32'h0004, 32'h99AABBCC});
      ops.push_back('{1'b1, 2'd2, 1'b0, 32'h0008, 32'h0D0E0F10});
      ops.push_back('{1'b1, 2'd2, 1'b0, 32'h0006, 32'h11223344});
      ops.push_back('{1'b0, 2'd2, 1'b0, 32'h0006, 32'h0});
      ops.push_back('{1'b0, 2'd1, 1'b1, 32'h0008, 32'h0});
      ops.push_back('{1'b0, 2'd1, 1'b1, 32'h0006, 32'h0});
      ops.push_back('{1'b0, 2'd2, 1'b0, 32'h0004, 32'h0});
      ops.push_back('{1'b1, 2'd1, 1'b0, 32'h0001, 32'h0000ABCD});
      ops.push_back('{1'b0, 2'd2, 1'b1, 32'h0000, 32'h0});
      foreach (ops[i]) begin
         e = mdl(ops[i].we, ops[i].sz, ops[i].uns, ops[i].a, ops[i].wd);
         run_op(ops[i], g, lat, ok);
         checks++;
         if (!ok || lat != 1 || g.we !== e.we || g.rdata !== e.rdata || g.err !== e.err) begin
            errors++;
            $display("FAIL misaligned[%0d] got lat=%0d we=%b rdata=%h err=%b want lat=1 we=%b rdata=%h err=%b",
                     i, lat, g.we, g.rdata, g.err, e.we, e.rdata, e.err);
         end
      end
   endtask

   task automatic test_wrap();
      op_t ops[$]; exp_t e, g; int lat; bit ok;
      ops.push_back('{1'b1, 2'd0, 1'b0, 32'hFFFE, 32'h01});
      ops.push_back('{1'b1, 2'd0, 1'b0, 32'hFFFF, 32'h02});
      ops.push_back('{1'b1, 2'd0, 1'b0, 32'h0000, 32'h03});
      ops.push_back('{1'b1, 2'd0, 1'b0, 32'h0001, 32'h04});
      ops.push_back('{1'b0, 2'd2, 1'b0, 32'hFFFE, 32'h0});
      ops.push_back('{1'b1, 2'd2, 1'b0, 32'hFFFE, 32'hA1B2C3D4});
      ops.push_back('{1'b0, 2'd1, 1'b1, 32'h0000, 32'h0});
      ops.push_back('{1'b0, 2'd1, 1'b1, 32'hFFFE, 32'h0});
      ops.push_back('{1'b0, 2'd0, 1'b0, 32'hFFFF, 32'h0});
      foreach (ops[i]) begin
         e = mdl(ops[i].we, ops[i].sz, ops[i].uns, ops[i].a, ops[i].wd);
         run_op(ops[i], g, lat, ok);
         checks++;
         if (!ok || lat != 1 || g.we !== e.we || g.rdata !== e.rdata || g.err !== e.err) begin
            errors++;
            $display("FAIL wrap[%0d] got lat=%0d we=%b rdata=%h err=%b want lat=1 we=%b rdata=%h err=%b",
                     i, lat, g.we, g.rdata, g.err, e.we, e.rdata, e.err);
         end
      end
   endtask

   task automatic test_back_pressure();
      logic [31:0] ad[4];
      exp_t ex[4];
      logic [31:0] rds[$];
      logic [31:0] hold;
      bit ok0, ok1, ok2, ok3;
      int got, cyc;
      ad[0] = 32'h0100; ad[1] = 32'h0200; ad[2] = 32'h0000; ad[3] = 32'h0004;
      for (int i = 0; i < 4; i++) ex[i] = mdl(1'b0, 2'd2, 1'b0, ad[i], 32'h0);
      got = 0; cyc = 0;
      Rsp_ready = 1'b0;
      issue(1'b0, 2'd2, 1'b0, ad[0], 32'h0, ok0);
      issue(1'b0, 2'd2, 1'b0, ad[1], 32'h0, ok1);
      checks++;
      if (!ok0 || !ok1 || Req_ready !== 1'b0 || Rsp_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_stall_entry got ok=%0d%0d ready=%b valid=%b want 11 0 1",
                  ok0, ok1, Req_ready, Rsp_valid);
      end
      hold = Rsp_rdata;
      checks++;
      if (hold !== ex[0].rdata) begin
         errors++;
         $display("FAIL bp_first_data got %h want %h", hold, ex[0].rdata);
      end
      Req_valid = 1'b1; Req_we = 1'b0; Req_size = 2'd2; Req_unsigned = 1'b0; Req_addr = ad[2];
      repeat (3) begin
         @(negedge Clk);
         checks++;
         if (Req_ready !== 1'b0 || Rsp_valid !== 1'b1 || Rsp_rdata !== hold) begin
            errors++;
            $display("FAIL bp_hold got ready=%b valid=%b rdata=%h want 0 1 %h",
                     Req_ready, Rsp_valid, Rsp_rdata, hold);
         end
      end
      Rsp_ready = 1'b1;
      fork
         begin
            issue(1'b0, 2'd2, 1'b0, ad[2], 32'h0, ok2);
            issue(1'b0, 2'd2, 1'b0, ad[3], 32'h0, ok3);
         end
         begin
            while (got < 4 && cyc < 50) begin
               if (Rsp_valid) begin rds.push_back(Rsp_rdata); got++; end
               @(negedge Clk);
               cyc++;
            end
         end
      join
      checks++;
      if (got != 4 || !ok2 || !ok3) begin
         errors++;
         $display("FAIL bp_count got %0d responses ok=%0d%0d want 4", got, ok2, ok3);
      end
      for (int i = 0; i < rds.size(); i++) begin
         checks++;
         if (rds[i] !== ex[i].rdata) begin
            errors++;
            $display("FAIL bp_order[%0d] got %h want %h", i, rds[i], ex[i].rdata);
         end
      end
      @(negedge Clk);
      checks++;
      if (Rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_extra got valid=%b want 0", Rsp_valid);
      end
   endtask

   task automatic test_reset_midflight();
      bit ok;
      int seen;
      seen = 0;
      issue(1'b0, 2'd2, 1'b0, 32'h0100, 32'h0, ok);
      Reset_n = 1'b0;
      @(negedge Clk);
      checks++;
      if (!ok || Rsp_valid !== 1'b0 || Req_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_in got ok=%0d valid=%b ready=%b want 1 0 1", ok, Rsp_valid, Req_ready);
      end
      @(negedge Clk);
      Reset_n = 1'b1;
      repeat (6) begin
         @(negedge Clk);
         if (Rsp_valid) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL rst_mid_drop got %0d response cycles want 0", seen);
      end
   endtask

   task automatic test_random();
      op_t ops[$];
      exp_t e;
      int got, cyc, n;
      got = 0; cyc = 0;
      for (int i = 0; i < 32; i++)
         ops.push_back('{1'b1, 2'd2, 1'b0, 32'(4*i), $urandom});
      for (int i = 0; i < 80; i++)
         ops.push_back('{1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                         32'($urandom_range(0, 124)), $urandom});
      n = ops.size();
      fork
         begin
            foreach (ops[i]) begin
               bit ok;
               expq.push_back(mdl(ops[i].we, ops[i].sz, ops[i].uns, ops[i].a, ops[i].wd));
               issue(ops[i].we, ops[i].sz, ops[i].uns, ops[i].a, ops[i].wd, ok);
               checks++;
               if (!ok) begin
                  errors++;
                  $display("FAIL rand_accept[%0d] got no accept within budget want accept", i);
               end
               if ($urandom_range(0, 3) == 0) @(negedge Clk);
            end
         end
         begin
            while (got < n && cyc < 4000) begin
               @(negedge Clk);
               cyc++;
               Rsp_ready = ($urandom_range(0, 3) != 0);
               if (Rsp_valid && Rsp_ready) begin
                  checks++;
                  if (expq.size() == 0) begin
                     errors++;
                     $display("FAIL rand_extra got rdata=%h want no response", Rsp_rdata);
                  end else begin
                     e = expq.pop_front();
                     if (Rsp_we !== e.we || Rsp_rdata !== e.rdata || Rsp_err !== e.err) begin
                        errors++;
                        $display("FAIL rand_rsp[%0d] got we=%b rdata=%h err=%b want we=%b rdata=%h err=%b",
                                 got, Rsp_we, Rsp_rdata, Rsp_err, e.we, e.rdata, e.err);
                     end
                  end
                  got++;
               end
            end
         end
      join
      Rsp_ready = 1'b1;
      repeat (3) @(negedge Clk);
      checks++;
      if (got != n || Rsp_valid !== 1'b0 || expq.size() != 0) begin
         errors++;
         $display("FAIL rand_total got %0d responses valid=%b pending=%0d want %0d 0 0",
                  got, Rsp_valid, expq.size(), n);
      end
   endtask

   initial begin
      test_reset();
      test_word_roundtrip();
      test_sub_word();
      test_misaligned();
      test_wrap();
      test_back_pressure();
      test_reset_midflight();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
